mac_quantizer: RTL

Downstream stage of the 32x32 MAC. It samples the 64-bit signed accumulator output on a strobe, then applies an arithmetic right shift with round-half-up and saturates the result to 32 bits signed. Results are buffered in a small FIFO and presented on a valid/ready stream to the consumer. Sampling is never back-pressured: results that find the FIFO full are dropped and counted.

---
 rtl/mac_quantizer.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/mac_quantizer.sv
`default_nettype none
// ============================================================================
// Module      : mac_quantizer
// Description : Output stage of the 32x32 MAC. Captures the signed
//               accumulator on a strobe, applies an arithmetic right shift
//               with round-half-up, saturates to OUT_WIDTH bits signed and
//               buffers results in a small FIFO drained over valid/ready.
//               Sampling is never back-pressured; results that find the
//               FIFO full are dropped and counted (saturating at 255).
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk        in   1            clock, all state on rising edge
//   rst_an     in   1            asynchronous active-low reset
//   acc_in     in   IN_WIDTH     signed accumulator value
//   sample     in   1            capture acc_in/shift this cycle
//   shift      in   SHIFT_WIDTH  unsigned right-shift amount
//   out_data   out  OUT_WIDTH    quantized result at FIFO head
//   out_sat    out  1            head entry was saturated
//   out_valid  out  1            FIFO non-empty
//   out_ready  in   1            consumer accepts head
//   drop_count out  8            results dropped on full FIFO (saturating)
// ============================================================================
module mac_quantizer #(
    parameter int IN_WIDTH    = 64,
    parameter int OUT_WIDTH   = 32,
    parameter int SHIFT_WIDTH = 6,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst_an,
    input  logic [IN_WIDTH-1:0]    acc_in,
    input  logic                   sample,
    input  logic [SHIFT_WIDTH-1:0] shift,
    output logic [OUT_WIDTH-1:0]   out_data,
    output logic                   out_sat,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [7:0]             drop_count
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    // One extra bit of headroom so adding the rounding constant to the most
    // positive accumulator value cannot wrap.
    localparam int EXT_W   = IN_WIDTH + 1;
    localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = OUT_WIDTH + 1;

    localparam logic [EXT_W-1:0]        EXT_ONE   = {{IN_WIDTH{1'b0}}, 1'b1};
    localparam logic signed [EXT_W-1:0] SAT_MAX   = (EXT_ONE << (OUT_WIDTH - 1)) - EXT_ONE;
    localparam logic signed [EXT_W-1:0] SAT_MIN   = ~SAT_MAX;
    localparam logic [OUT_WIDTH-1:0]    OUT_MAX   = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic [OUT_WIDTH-1:0]    OUT_MIN   = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    localparam logic [SHIFT_WIDTH-1:0]  SHIFT_ONE = {{(SHIFT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [SHIFT_WIDTH-1:0]  SHIFT_ZERO = '0;
    localparam logic [PTR_W-1:0]        PTR_ONE   = PTR_W'(1);
    localparam logic [CNT_W-1:0]        CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]        CNT_ZERO  = '0;
    localparam logic [CNT_W-1:0]        CNT_FULL  = CNT_W'(FIFO_DEPTH);
    localparam logic [7:0]              DROP_MAX  = 8'hFF;

    // ------------------------------------------------------------------------
    // Stage 1: capture
    // ------------------------------------------------------------------------
    logic                   r_s1_valid;
    logic [IN_WIDTH-1:0]    r_s1_acc;
    logic [SHIFT_WIDTH-1:0] r_s1_shift;

    always_ff @(posedge clk or negedge rst_an) begin
        if (!rst_an) begin
            r_s1_valid <= 1'b0;
            r_s1_acc   <= '0;
            r_s1_shift <= '0;
        end else begin
            r_s1_valid <= sample;
            if (sample) begin
                r_s1_acc   <= acc_in;
                r_s1_shift <= shift;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stage 2 datapath: round half toward +inf, then saturate
    // ------------------------------------------------------------------------
    logic signed [EXT_W-1:0] w_ext;
    logic signed [EXT_W-1:0] w_round;
    logic signed [EXT_W-1:0] w_sum;
    logic signed [EXT_W-1:0] w_shifted;
    logic [OUT_WIDTH-1:0]    w_q_data;
    logic                    w_q_sat;

    always_comb begin
        w_ext = {r_s1_acc[IN_WIDTH-1], r_s1_acc};
        // Half an LSB of the shifted result; a zero shift passes through.
        if (r_s1_shift == SHIFT_ZERO) begin
            w_round = '0;
        end else begin
            w_round = EXT_ONE << (r_s1_shift - SHIFT_ONE);
        end
        w_sum     = w_ext + w_round;
        w_shifted = w_sum >>> r_s1_shift;
    end

    always_comb begin
        w_q_data = w_shifted[OUT_WIDTH-1:0];
        w_q_sat  = 1'b0;
        if (w_shifted > SAT_MAX) begin
            w_q_data = OUT_MAX;
            w_q_sat  = 1'b1;
        end else if (w_shifted < SAT_MIN) begin
            w_q_data = OUT_MIN;
            w_q_sat  = 1'b1;
        end
    end

    logic                 r_s2_valid;
    logic [OUT_WIDTH-1:0] r_s2_data;
    logic                 r_s2_sat;

    always_ff @(posedge clk or negedge rst_an) begin
        if (!rst_an) begin
            r_s2_valid <= 1'b0;
            r_s2_data  <= '0;
            r_s2_sat   <= 1'b0;
        end else begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_data <= w_q_data;
                r_s2_sat  <= w_q_sat;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------------
    logic [ENTRY_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [7:0]         r_drop_count;

    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_drop;

    assign out_valid = (r_count != CNT_ZERO);
    assign w_full    = (r_count == CNT_FULL);
    assign w_pop     = out_valid & out_ready;
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    assign w_push    = r_s2_valid & (~w_full | w_pop);
    assign w_drop    = r_s2_valid & w_full & ~w_pop;

    always_ff @(posedge clk or negedge rst_an) begin
        if (!rst_an) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= {r_s2_data, r_s2_sat};
                r_wr_ptr        <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_an) begin
        if (!rst_an) begin
            r_drop_count <= '0;
        end else if (w_drop && (r_drop_count != DROP_MAX)) begin
            r_drop_count <= r_drop_count + 8'd1;
        end
    end

    // Head entry is presented directly; when empty it is a don't-care.
    assign {out_data, out_sat} = r_mem[r_rd_ptr];
    assign drop_count          = r_drop_count;

endmodule
`default_nettype wire
